snapshot_access_ctrl: RTL and testbench



---
 rtl/snapshot_pkg.sv | 32 +++
 rtl/snapshot_access_ctrl_addr_dec.sv | 35 +++
 rtl/snapshot_access_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_snapshot_access_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/snapshot_pkg.sv
// Shared types and helpers for the snapshot register access front end.
//   state_t    : access-sequence FSM state (IDLE, RD_SEQ, WR_SEQ)
//   BYTE_W     : bits per byte, used to turn a word width into a byte count
//   clog2      : ceil(log2(n)) usable in parameter expressions
//   word_bytes : bytes per bus word
//   part_cnt   : number of bus words that cover a register
package snapshot_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_SEQ = 2'd1,
    WR_SEQ = 2'd2
  } state_t;

  localparam int BYTE_W = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int word_bytes(input int dw);
    return dw / BYTE_W;
  endfunction

  function automatic int part_cnt(input int rw, input int dw);
    return (rw + dw - 1) / dw;
  endfunction

endpackage

// File: rtl/snapshot_access_ctrl_addr_dec.sv
// snapshot_addr_dec: combinational address decoder for the snapshot register.
//   req_addr : byte address of the request
//   hit      : address is word aligned and inside the register's word span
//   idx      : word offset from BASE_ADDR (meaningful only when hit)
module snapshot_addr_dec
  import snapshot_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int PARTITION_CNT = 2,
  parameter int ADDR_WIDTH    = 16,
  parameter int BASE_ADDR     = 0,
  parameter int IDX_W         = 1
) (
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  hit,
  output logic [IDX_W-1:0]      idx
);

  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int SH  = clog2(word_bytes(DATA_WIDTH));
  localparam logic [ADDR_WIDTH:0] BASE = AW1'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] ALGN = AW1'(word_bytes(DATA_WIDTH) - 1);
  localparam logic [ADDR_WIDTH:0] CNT  = AW1'(PARTITION_CNT);

  logic [ADDR_WIDTH:0] off;
  logic [ADDR_WIDTH:0] word;

  // One extra bit: an address below BASE wraps to a huge offset, so the
  // single word-count compare rejects both ends of the window.
  assign off  = {1'b0, req_addr} - BASE;
  assign word = off >> SH;
  assign idx  = IDX_W'(word);
  assign hit  = ((off & ALGN) == '0) && (word < CNT);

endmodule

// File: rtl/snapshot_access_ctrl.sv
// snapshot_access_ctrl: bus front end for one snapshot register.
//   req_*        : single-word read/write request, valid/ready
//   ack_*        : response data + error flag, valid/ready
//   snap_rd_en   : registered one-hot read strobe to the snapshot stage
//   snap_wr_en   : registered one-hot write strobe to the snapshot stage
//   snap_wr_data : request word replicated into every partition slot
//   snap_rd_data : downstream read data, one word per partition
//   soft_rst     : one-cycle snapshot clear when a write sequence is aborted
// Optional: define SNAPSHOT_SEQ_CHECK_EN to flag out-of-order reads and
// repeated partition writes on ack_err.
// Timing: accept at T, strobe at T+1 (read data sampled then), ack at T+2.
module snapshot_access_ctrl
  import snapshot_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_WIDTH     = 36,
  parameter int PARTITION_CNT = part_cnt(REG_WIDTH, DATA_WIDTH),
  parameter int ADDR_WIDTH    = 16,
  parameter int BASE_ADDR     = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_vld,
  output logic                                req_rdy,
  input  logic                                req_wr,
  input  logic [ADDR_WIDTH-1:0]               req_addr,
  input  logic [DATA_WIDTH-1:0]               req_wdata,
  output logic                                ack_vld,
  input  logic                                ack_rdy,
  output logic [DATA_WIDTH-1:0]               ack_rdata,
  output logic                                ack_err,
  output logic [PARTITION_CNT-1:0]            snap_rd_en,
  output logic [PARTITION_CNT-1:0]            snap_wr_en,
  output logic [DATA_WIDTH*PARTITION_CNT-1:0] snap_wr_data,
  input  logic [DATA_WIDTH*PARTITION_CNT-1:0] snap_rd_data,
  output logic                                soft_rst
);

  localparam int IDX_W = (PARTITION_CNT > 1) ? clog2(PARTITION_CNT) : 1;

  state_t                   state_q, state_d;
  logic [PARTITION_CNT-1:0] mask_q, mask_d;
  logic                     hit;
  logic [IDX_W-1:0]         idx;
  logic [PARTITION_CNT-1:0] oh;
  logic                     acc;
  logic                     abort;
  logic                     seq_err;

  // stage 1: accepted request waiting for its read-data sample
  logic                     s1_vld;
  logic                     s1_wr;
  logic                     s1_hit;
  logic                     s1_err;
  logic [IDX_W-1:0]         s1_idx;

  logic [PARTITION_CNT-1:0][DATA_WIDTH-1:0] rd_words;

  snapshot_addr_dec #(
    .DATA_WIDTH    (DATA_WIDTH),
    .PARTITION_CNT (PARTITION_CNT),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .BASE_ADDR     (BASE_ADDR),
    .IDX_W         (IDX_W)
  ) u_dec (
    .req_addr (req_addr),
    .hit      (hit),
    .idx      (idx)
  );

  assign rd_words = snap_rd_data;
  assign oh       = PARTITION_CNT'(1) << idx;
  assign req_rdy  = !s1_vld && !ack_vld;
  assign acc      = req_vld && req_rdy;
  assign abort    = acc && hit && !req_wr && (state_q == WR_SEQ);

  // ---------------- access-sequence FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  // Misses leave the FSM alone. A read in WR_SEQ behaves as if issued from
  // IDLE after the abort, so only the idx-0 / last-idx cases move state.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    if (acc && hit) begin
      if (req_wr) begin
        if (idx == '0) begin
          state_d = IDLE;
          mask_d  = '0;
        end else begin
          state_d = WR_SEQ;
          mask_d  = mask_q | oh;
        end
      end else begin
        mask_d = '0;
        if (idx == '0)
          state_d = (PARTITION_CNT > 1) ? RD_SEQ : IDLE;
        else if (idx == IDX_W'(PARTITION_CNT - 1))
          state_d = IDLE;
        else if (state_q == WR_SEQ)
          state_d = IDLE;
      end
    end
  end

  // ---------------- sequence checking ----------------
`ifdef SNAPSHOT_SEQ_CHECK_EN
  logic [IDX_W-1:0] exp_idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      exp_idx_q <= '0;
    else if (acc && hit && !req_wr)
      exp_idx_q <= idx + 1'b1;
  end

  always_comb begin
    seq_err = 1'b0;
    if (hit) begin
      if (req_wr)
        seq_err = |(mask_q & oh);
      else
        seq_err = (idx != '0) && !((state_q == RD_SEQ) && (idx == exp_idx_q));
    end
  end
`else
  assign seq_err = 1'b0;
`endif

  // ---------------- strobes, sample and response ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld       <= 1'b0;
      s1_wr        <= 1'b0;
      s1_hit       <= 1'b0;
      s1_err       <= 1'b0;
      s1_idx       <= '0;
      snap_rd_en   <= '0;
      snap_wr_en   <= '0;
      snap_wr_data <= '0;
      soft_rst     <= 1'b0;
      ack_vld      <= 1'b0;
      ack_err      <= 1'b0;
      ack_rdata    <= '0;
    end else begin
      snap_rd_en <= '0;
      snap_wr_en <= '0;
      soft_rst   <= abort;

      if (acc) begin
        s1_vld       <= 1'b1;
        s1_wr        <= req_wr;
        s1_hit       <= hit;
        s1_idx       <= idx;
        s1_err       <= !hit || seq_err;
        snap_wr_data <= {PARTITION_CNT{req_wdata}};
        if (hit) begin
          if (req_wr) snap_wr_en <= oh;
          else        snap_rd_en <= oh;
        end
      end

      if (s1_vld) begin
        s1_vld    <= 1'b0;
        ack_vld   <= 1'b1;
        ack_err   <= s1_err;
        ack_rdata <= (s1_hit && !s1_wr) ? rd_words[s1_idx] : '0;
      end else if (ack_vld && ack_rdy) begin
        ack_vld   <= 1'b0;
        ack_err   <= 1'b0;
        ack_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_snapshot_access_ctrl.sv
// Bench for snapshot_access_ctrl (DATA_WIDTH 32, REG_WIDTH 36 -> 2 words).
// A transaction-level model predicts strobes, soft_rst and acks per cycle;
// the directed transactions also carry hand-computed literal expectations.
module tb_snapshot_access_ctrl;

  localparam int DW = 32;
  localparam int P  = 2;
`ifdef SNAPSHOT_SEQ_CHECK_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_vld, req_rdy, req_wr;
  logic [15:0]   req_addr;
  logic [DW-1:0] req_wdata;
  logic          ack_vld, ack_rdy, ack_err;
  logic [DW-1:0] ack_rdata;
  logic [P-1:0]  snap_rd_en, snap_wr_en;
  logic [DW*P-1:0] snap_wr_data, snap_rd_data;
  logic          soft_rst;
  logic [63:0]   dn_val;

  assign snap_rd_data = dn_val;

  snapshot_access_ctrl #(
    .DATA_WIDTH(32), .REG_WIDTH(36), .ADDR_WIDTH(16), .BASE_ADDR(0)
  ) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .ack_vld(ack_vld), .ack_rdy(ack_rdy), .ack_rdata(ack_rdata), .ack_err(ack_err),
    .snap_rd_en(snap_rd_en), .snap_wr_en(snap_wr_en),
    .snap_wr_data(snap_wr_data), .snap_rd_data(snap_rd_data),
    .soft_rst(soft_rst)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int soft_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct { int c; logic [31:0] d; bit e; } ack_t;
  ack_t        ackq[$];
  logic [1:0]  exp_rd   [2048];
  logic [1:0]  exp_wr   [2048];
  logic [31:0] exp_wd   [2048];
  bit          exp_soft [2048];
  int          mode;      // 0 idle, 1 reading, 2 writing
  int          nxt;       // next in-order read index
  bit          pend [P];

  task automatic model_flush();
    for (int i = 0; i < 2048; i++) begin
      exp_rd[i] = '0; exp_wr[i] = '0; exp_wd[i] = '0; exp_soft[i] = 1'b0;
    end
    ackq.delete();
    mode = 0; nxt = 0;
    for (int i = 0; i < P; i++) pend[i] = 1'b0;
  endtask

  // called in the cycle where req_vld && req_rdy; accept edge ends this cycle
  task automatic model_accept();
    bit h, e;
    int i;
    logic [31:0] d;
    h = (int'(req_addr) < P * 4) && (int'(req_addr) % 4 == 0);
    i = int'(req_addr) / 4;
    e = !h;
    d = '0;
    if (h) begin
      if (req_wr) begin
        exp_wr[cyc+1] = 2'b01 << i;
        exp_wd[cyc+1] = req_wdata;
        if (SEQ && i > 0 && pend[i]) e = 1'b1;
        if (i == 0) begin
          mode = 0;
          for (int k = 0; k < P; k++) pend[k] = 1'b0;
        end else begin
          mode = 2;
          pend[i] = 1'b1;
        end
      end else begin
        exp_rd[cyc+1] = 2'b01 << i;
        d = dn_val[32*i +: 32];
        if (mode == 2) begin
          exp_soft[cyc+1] = 1'b1;
          mode = 0;
          for (int k = 0; k < P; k++) pend[k] = 1'b0;
        end
        if (SEQ && i > 0 && !(mode == 1 && i == nxt)) e = 1'b1;
        nxt = i + 1;
        if (i == 0) mode = 1;
        else if (i == P - 1) mode = 0;
      end
    end
    ackq.push_back('{cyc + 2, d, e});
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin : cmp
    bit exp_vld;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        chk("rst_req_rdy", req_rdy, 1);
        chk("rst_ack_vld", ack_vld, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_ack_rdata", ack_rdata, 0);
        chk("rst_strobes", {snap_wr_en, snap_rd_en}, 0);
        chk("rst_soft_rst", soft_rst, 0);
        model_flush();
      end else if (rst === 1'b0) begin
        chk("rd_en", snap_rd_en, exp_rd[cyc]);
        chk("wr_en", snap_wr_en, exp_wr[cyc]);
        chk("soft_rst", soft_rst, exp_soft[cyc]);
        if (soft_rst === 1'b1) soft_cnt++;
        if (exp_wr[cyc] != 0) chk("wr_data", snap_wr_data, {exp_wd[cyc], exp_wd[cyc]});
        exp_vld = (ackq.size() > 0) && (cyc >= ackq[0].c);
        chk("ack_vld", ack_vld, exp_vld);
        if (ack_vld && exp_vld) begin
          chk("ack_rdata", ack_rdata, ackq[0].d);
          chk("ack_err", ack_err, ackq[0].e);
        end
        chk("req_rdy", req_rdy, ackq.size() == 0);
        if (ack_vld && ack_rdy && exp_vld) void'(ackq.pop_front());
        if (req_vld && req_rdy) model_accept();
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_txn(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                        input logic [3:0] exp_strb, input bit exp_sr,
                        input logic [31:0] exp_d, input bit exp_e,
                        input int stall, input string name);
    int n;
    @(posedge clk); #1;
    req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
    ack_rdy = (stall == 0);
    n = 0;
    while (!req_rdy && n < 20) begin @(posedge clk); #1; n++; end
    chk({name, "_rdy_wait"}, req_rdy, 1);
    @(posedge clk); #1;              // accept edge passed: now in T+1
    req_vld = 1'b0;
    chk({name, "_strobe"}, {snap_wr_en, snap_rd_en}, exp_strb);
    chk({name, "_soft"}, soft_rst, exp_sr);
    n = 0;
    while (!ack_vld && n < 10) begin @(posedge clk); #1; n++; end
    chk({name, "_ack_lat"}, n, 1);
    chk({name, "_ack_vld"}, ack_vld, 1);
    chk({name, "_data"}, ack_rdata, exp_d);
    chk({name, "_err"}, ack_err, exp_e);
    if (stall > 0) begin
      dn_val = ~dn_val;              // ack data must not follow the bus
      repeat (stall) begin
        @(posedge clk); #1;
        chk({name, "_hold_vld"}, ack_vld, 1);
        chk({name, "_hold_data"}, ack_rdata, exp_d);
        chk({name, "_hold_rdy"}, req_rdy, 0);
      end
      dn_val = ~dn_val;
      ack_rdy = 1'b1;
    end
    @(posedge clk); #1;              // handshake edge passed
    chk({name, "_ack_done"}, ack_vld, 0);
    chk({name, "_rdy_back"}, req_rdy, 1);
  endtask

  initial begin : main
    rst = 1'b0; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    ack_rdy = 1'b1; dn_val = 64'h0000_000A_1234_5678;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    do_txn(0, 16'h0, 0,            4'b0001, 0, 32'h1234_5678, 0, 0, "rd0");
    do_txn(0, 16'h4, 0,            4'b0010, 0, 32'h0000_000A, 0, 0, "rd1");
    do_txn(1, 16'h4, 32'h5,        4'b1000, 0, 32'h0,         0, 0, "wr1");
    do_txn(1, 16'h0, 32'hDEADBEEF, 4'b0100, 0, 32'h0,         0, 0, "wr0");
    do_txn(0, 16'h0, 0,            4'b0001, 0, 32'h1234_5678, 0, 0, "rd0_after_commit");
    do_txn(1, 16'h4, 32'h77,       4'b1000, 0, 32'h0,         0, 0, "wr_in_rdseq");
    do_txn(0, 16'h0, 0,            4'b0001, 1, 32'h1234_5678, 0, 0, "rd_abort");
    do_txn(0, 16'h8, 0,            4'b0000, 0, 32'h0,         1, 0, "rd_miss");
    do_txn(0, 16'h4, 0,            4'b0010, 0, 32'h0000_000A, 0, 0, "rd1_inorder");
    do_txn(0, 16'h4, 0,            4'b0010, 0, 32'h0000_000A, SEQ, 0, "rd1_idle");
    do_txn(0, 16'h2, 0,            4'b0000, 0, 32'h0,         1, 0, "rd_misalign");
    do_txn(1, 16'h4, 32'h1,        4'b1000, 0, 32'h0,         0, 0, "wr1_a");
    do_txn(1, 16'h4, 32'h2,        4'b1000, 0, 32'h0,         SEQ, 0, "wr1_again");
    do_txn(1, 16'h0, 32'h3,        4'b0100, 0, 32'h0,         0, 0, "wr0_commit");
    dn_val = 64'h0000_0005_CAFE_F00D;
    do_txn(0, 16'h0, 0,            4'b0001, 0, 32'hCAFE_F00D, 0, 5, "rd0_stall");
    do_txn(0, 16'h4, 0,            4'b0010, 0, 32'h0000_0005, 0, 0, "rd1_new");

    // reset while a read is in flight: the ack must never appear
    @(posedge clk); #1;
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 16'h4;
    @(posedge clk); #1;
    req_vld = 1'b0;
    chk("rstmid_strobe", snap_rd_en, 2'b10);
    rst = 1'b1;
    #1 chk("rstmid_strobe_cleared", snap_rd_en, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("rstmid_no_ack", ack_vld, 0);

    do_txn(0, 16'h0, 0,            4'b0001, 0, 32'hCAFE_F00D, 0, 0, "rd0_post_rst");
    chk("soft_pulse_count", soft_cnt, 1);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, want summary");
    $fatal(1, "watchdog");
  end

endmodule
